// File: rtl/matmul_apb_master.sv
`default_nettype none
// =============================================================================
// matmul_apb_master : command-driven APB master for the matmul slave port
// Revision: 1.0
// =============================================================================
module matmul_apb_master #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic                            cmd_write_i,
  input  logic                            cmd_wait_i,
  input  logic [ADDR_WIDTH-1:0]           cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]            cmd_wdata_i,
  input  logic [BUS_WIDTH/DATA_WIDTH-1:0] cmd_strb_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [BUS_WIDTH-1:0]            rsp_rdata_o,
  output logic                            rsp_err_o,
  output logic                            rsp_timeout_o,
  output logic                            psel_o,
  output logic                            penable_o,
  output logic                            pwrite_o,
  output logic [ADDR_WIDTH-1:0]           paddr_o,
  output logic [BUS_WIDTH-1:0]            pwdata_o,
  output logic [BUS_WIDTH/DATA_WIDTH-1:0] pstrb_o,
  input  logic                            pready_i,
  input  logic                            pslverr_i,
  input  logic [BUS_WIDTH-1:0]            prdata_i,
  input  logic                            busy_i
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd1;
  localparam logic [2:0] ST_SETUP     = 3'd2;
  localparam logic [2:0] ST_ACCESS    = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [BUS_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [BUS_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [MAX_DIM-1:0]    pstrb_q, pstrb_d;

  logic                  accept;
  logic                  tmo_hit;
  logic [CNT_W-1:0]      cnt_inc;

  assign accept  = cmd_valid_i & cmd_ready_q;
  // The counter holds the number of cycles already spent, so the abort fires
  // during the TIMEOUT-th cycle of waiting.
  assign tmo_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (accept) state_d = cmd_wait_i ? ST_WAIT_BUSY : ST_SETUP;
      ST_WAIT_BUSY: begin
        if (!busy_i)      state_d = ST_SETUP;
        else if (tmo_hit) state_d = ST_RESP;
      end
      ST_SETUP:     state_d = ST_ACCESS;
      ST_ACCESS:    if (pready_i || tmo_hit) state_d = ST_RESP;
      ST_RESP:      if (rsp_ready_i) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          pwrite_d    = cmd_write_i;
          paddr_d     = cmd_addr_i;
          pwdata_d    = cmd_write_i ? cmd_wdata_i : '0;
          pstrb_d     = cmd_write_i ? cmd_strb_i : '0;
          psel_d      = !cmd_wait_i;
        end
      end
      ST_WAIT_BUSY: begin
        if (!busy_i) begin
          psel_d = 1'b1;
        end else if (tmo_hit) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
          rsp_err_d     = pslverr_i;
          rsp_timeout_d = 1'b0;
        end else if (tmo_hit) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        cmd_ready_d = 1'b0;
      end
    endcase
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_apb_master.sv
`default_nettype none
// =============================================================================
// tb_matmul_apb_master : directed bench with response scoreboard and APB slave
// Revision: 1.0
// =============================================================================
module tb_matmul_apb_master;

  localparam int TB_TIMEOUT = 12;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i, cmd_wait_i;
  logic [31:0] cmd_addr_i;
  logic [15:0] cmd_wdata_i;
  logic [1:0]  cmd_strb_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
  logic [15:0] rsp_rdata_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o;
  logic [15:0] pwdata_o;
  logic [1:0]  pstrb_o;
  logic        pready_i, pslverr_i, busy_i;
  logic [15:0] prdata_i;

  logic [7:0]  slave_wait;
  logic        slave_hang;
  logic        slave_err;
  logic [15:0] slave_rdata;
  logic [7:0]  acc_cycles;

  int   n_checks = 0;
  int   n_errors = 0;
  rsp_t exp_q[$];

  always #5 clk_i = ~clk_i;

  matmul_apb_master #(
    .DATA_WIDTH(8), .BUS_WIDTH(16), .ADDR_WIDTH(32), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_wait_i(cmd_wait_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i),
    .busy_i(busy_i)
  );

  // APB slave: inserts slave_wait wait states, or never answers when hung.
  always @(posedge clk_i)
    acc_cycles <= (psel_o && penable_o && !pready_i) ? acc_cycles + 8'd1 : 8'd0;
  assign pready_i  = psel_o && penable_o && !slave_hang && (acc_cycles >= slave_wait);
  assign pslverr_i = slave_err;
  assign prdata_i  = slave_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] apb_snap();
    return {11'd0, psel_o, penable_o, pwrite_o, pstrb_o, pwdata_o, paddr_o};
  endfunction

  function automatic logic [63:0] apb_exp(input logic sel, input logic en, input logic wr,
                                          input logic [1:0] strb, input logic [15:0] wd,
                                          input logic [31:0] addr);
    return {11'd0, sel, en, wr, strb, wd, addr};
  endfunction

  function automatic logic [63:0] rsp_snap();
    return {44'd0, cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o};
  endfunction

  // Scoreboard monitor: a response is consumed on the edge following a
  // negedge that sees valid and ready together.
  always @(negedge clk_i) begin
    if (rst_ni && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata_o, e.rdata);
        check("rsp_err", rsp_err_o, e.err);
        check("rsp_timeout", rsp_timeout_o, e.tmo);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic wr, input logic wt, input logic [31:0] addr,
                      input logic [15:0] wd, input logic [1:0] strb);
    int n;
    n = 0;
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_wait_i  = wt;
    cmd_addr_i  = addr;
    cmd_wdata_i = wd;
    cmd_strb_i  = strb;
    while (!cmd_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("cmd_accept", cmd_ready_o, 1'b1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_wait_i = 1'b0;
    cmd_addr_i = '0; cmd_wdata_i = '0; cmd_strb_i = '0; rsp_ready_i = 1'b1;
    busy_i = 1'b0; slave_wait = 8'd0; slave_hang = 1'b0; slave_err = 1'b0;
    slave_rdata = 16'h0000;
    repeat (3) @(negedge clk_i);
    check("reset_apb", apb_snap(), 64'd0);
    check("reset_rsp", rsp_snap(), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("ready_after_reset", cmd_ready_o, 1'b1);

    // Write, zero wait states: SETUP, ACCESS, then response at accept+3.
    exp_q.push_back('{16'h0000, 1'b0, 1'b0});
    send(1'b1, 1'b0, 32'h0, 16'h0025, 2'b11);
    check("wr_setup", apb_snap(), apb_exp(1, 0, 1, 2'b11, 16'h0025, 32'h0));
    check("wr_setup_ready", cmd_ready_o, 1'b0);
    @(negedge clk_i);
    check("wr_access", apb_snap(), apb_exp(1, 1, 1, 2'b11, 16'h0025, 32'h0));
    @(negedge clk_i);
    check("wr_resp", {psel_o, penable_o, rsp_valid_o}, 3'b001);
    @(negedge clk_i);
    check("wr_idle", {cmd_ready_o, rsp_valid_o}, 2'b10);

    // Read with two wait states.
    slave_wait = 8'd2; slave_rdata = 16'hBEEF;
    exp_q.push_back('{16'hBEEF, 1'b0, 1'b0});
    send(1'b0, 1'b0, 32'h20, 16'h7777, 2'b11);
    check("rd_setup", apb_snap(), apb_exp(1, 0, 0, 2'b00, 16'h0, 32'h20));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("rd_access_hold", apb_snap(), apb_exp(1, 1, 0, 2'b00, 16'h0, 32'h20));
    end
    @(negedge clk_i);
    check("rd_resp", {psel_o, penable_o, rsp_valid_o}, 3'b001);
    @(negedge clk_i);
    slave_wait = 8'd0;

    // Wait for busy to drop before starting the transfer.
    busy_i = 1'b1;
    exp_q.push_back('{16'h0000, 1'b0, 1'b0});
    send(1'b1, 1'b1, 32'h4, 16'h1234, 2'b01);
    for (int i = 0; i < 10; i++) begin
      check("busy_no_psel", psel_o, 1'b0);
      @(negedge clk_i);
    end
    busy_i = 1'b0;
    check("busy_last_no_psel", psel_o, 1'b0);
    @(negedge clk_i);
    check("busy_setup", apb_snap(), apb_exp(1, 0, 1, 2'b01, 16'h1234, 32'h4));
    repeat (3) @(negedge clk_i);
    check("busy_done_idle", cmd_ready_o, 1'b1);

    // Slave error; busy is ignored without cmd_wait.
    slave_err = 1'b1; busy_i = 1'b1;
    exp_q.push_back('{16'h0000, 1'b1, 1'b0});
    send(1'b1, 1'b0, 32'h2, 16'hA5A5, 2'b01);
    check("slverr_setup", {psel_o, penable_o}, 2'b10);
    repeat (3) @(negedge clk_i);
    slave_err = 1'b0; busy_i = 1'b0;

    // ACCESS timeout: slave never answers.
    slave_hang = 1'b1;
    exp_q.push_back('{16'h0000, 1'b1, 1'b1});
    send(1'b0, 1'b0, 32'h8, 16'h0, 2'b00);
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      @(negedge clk_i);
      check("tmo_access_hold", {psel_o, penable_o}, 2'b11);
    end
    @(negedge clk_i);
    check("tmo_access_drop", {psel_o, penable_o, rsp_valid_o}, 3'b001);
    @(negedge clk_i);
    slave_hang = 1'b0;

    // WAIT_BUSY timeout: no APB transfer at all.
    busy_i = 1'b1;
    exp_q.push_back('{16'h0000, 1'b1, 1'b1});
    send(1'b1, 1'b1, 32'hC, 16'h5555, 2'b11);
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      check("tmo_busy_no_psel", psel_o, 1'b0);
      @(negedge clk_i);
    end
    check("tmo_busy_resp", {psel_o, rsp_valid_o}, 2'b01);
    busy_i = 1'b0;
    @(negedge clk_i);

    // Response back-pressure.
    rsp_ready_i = 1'b0; slave_rdata = 16'h5A5A;
    exp_q.push_back('{16'h5A5A, 1'b0, 1'b0});
    send(1'b0, 1'b0, 32'h10, 16'h0, 2'b00);
    repeat (2) @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      check("rsp_hold", rsp_snap(), {44'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h5A5A});
      @(negedge clk_i);
    end
    @(posedge clk_i);
    #1 rsp_ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("rsp_release_idle", {cmd_ready_o, rsp_valid_o}, 2'b10);

    // Reset during ACCESS discards the command.
    slave_hang = 1'b1;
    send(1'b0, 1'b0, 32'h30, 16'h0, 2'b00);
    @(negedge clk_i);
    check("rst_in_access", {psel_o, penable_o}, 2'b11);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("rst_mid_apb", apb_snap(), 64'd0);
    check("rst_mid_rsp", rsp_snap(), 64'd0);
    rst_ni = 1'b1; slave_hang = 1'b0;
    @(negedge clk_i);
    check("rst_mid_ready", {cmd_ready_o, rsp_valid_o}, 2'b10);

    // Normal operation resumes after reset.
    slave_rdata = 16'h0F0F;
    exp_q.push_back('{16'h0F0F, 1'b0, 1'b0});
    send(1'b0, 1'b0, 32'h40, 16'h0, 2'b00);
    repeat (5) @(negedge clk_i);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
